score_text_overlay: RTL and testbench
=====================================

// Module: score_text_overlay
// PURPOSE
//  Renders an unsigned binary score as DIGITS decimal characters at a fixed screen position, using ascii_rom_score (8x16 glyphs).
//  Sits in the VGA pixel path beside the other text blocks; its rgb/text_on are muxed by the top-level colour mux.
//  Adds sequential binary-to-BCD conversion, saturation, leading-zero blanking, integer scaling and tear-free frame-boundary commit.
// PARAMETERS
//  DIGITS     4       number of decimal characters shown (1..6)
//  SCORE_W    14      width of score_in (bits)
//  X0         24      left pixel column of first character
//  Y0         20      top pixel row of characters
//  SCALE_LOG2 0       glyph magnification 2**SCALE_LOG2 (0..2)
//  LZ_BLANK   1       1 = leading zeros rendered as space (7'h20)
//  V_ACTIVE   480     first non-visible line; commit window is y >= V_ACTIVE
//  FG         12'hFFF foreground colour
//  BG         12'h000 background colour inside and outside text region
// PORTS
//  clk         in  1        pixel clock
//  reset       in  1        synchronous, active-high
//  video_on    in  1        active-video flag aligned with x,y
//  x           in  10       pixel column
//  y           in  10       pixel row
//  score_in    in  SCORE_W  new score value
//  score_load  in  1        1-cycle strobe; accepted only when busy==0
//  busy        out 1        conversion in progress
//  text_on     out 1        glyph pixel lit (registered, aligned with rgb)
//  rgb         out 12       pixel colour (registered)
// BEHAVIOUR
//  Reset: rgb=12'h000, text_on=0, busy=0, FSM=IDLE, pending=0, displayed and pending BCD all zero.
//  FSM IDLE: score_load&!busy -> capture score_in, saturate flag = (score_in > 10**DIGITS-1), go CONV, busy=1 next cycle.
//  CONV: double-dabble, one shift per clock, exactly SCORE_W cycles (add-3 on digits >=5 before each shift).
//   After last shift -> DONE: pending BCD = result, or all 9s if saturate flag; pending=1; busy=0; back to IDLE.
//   busy high for SCORE_W+1 cycles counting the DONE cycle; load strobe while busy is ignored (no queueing).
//  Commit: on any cycle with pending=1 and y >= V_ACTIVE, displayed BCD <= pending BCD, pending<=0.
//   A newer conversion finishing before commit overwrites pending (latest wins). Display never changes while y < V_ACTIVE.
//   Commit and DONE in same cycle: DONE value written to pending, committed value is the older one; new one commits next eligible cycle.
//  Geometry: CW=8<<SCALE_LOG2, CH=16<<SCALE_LOG2. Region: X0<=x<X0+DIGITS*CW and Y0<=y<Y0+CH.
//   dx=x-X0, dy=y-Y0; digit idx = dx>>(3+SCALE_LOG2) (0 = most significant, leftmost);
//   col = (dx>>SCALE_LOG2)&7; row = (dy>>SCALE_LOG2)&15.
//  Char code = 7'h30+digit; with LZ_BLANK, zeros left of first nonzero digit -> 7'h20; last digit never blanked.
//  ROM addr = {char[6:0], row[3:0]}; ROM data valid 1 cycle after addr. Bit = data[~col] (MSB is leftmost pixel).
//  Pipeline: stage0 regs addr; stage1 carries col, in_region, video_on (delayed 1); stage2 registers rgb/text_on.
//   Latency x,y,video_on -> rgb,text_on = 2 clocks exactly; every input pixel produces one output pixel (no stalls).
//  Output: video_on_d=0 -> rgb=12'h000, text_on=0; else lit -> FG, text_on=1; else BG, text_on=0.
//  Arithmetic: region compares in 11 bits (no wrap when X0+DIGITS*CW > 1023; excess clipped).
//  Reset mid-conversion: aborts, busy=0, pending cleared, display zeroed; load accepted first cycle after reset.
// TESTING
//  Reset: hold reset 3 clk, sweep frame -> rgb=0 outside region; display shows "   0" (LZ_BLANK=1) / "0000" (LZ_BLANK=0).
//  Load 1234 at y=100 -> busy high 15 clk; glyphs unchanged until y=480; next frame pixels match ROM for "1234".
//  Load 12000 (DIGITS=4) -> displays "9999"; load 7 -> "   7"; load 0 -> "   0".
//  Second load 1 clk after first accepted (busy=1) -> ignored; only first value displayed.
//  Two loads completing before vblank (500 then 42) -> only "  42" ever displayed, never "500".
//  Single-pixel probe x=24,y=20, video_on toggled -> rgb follows 2 clk later; SCALE_LOG2=1 -> each glyph bit covers 2x2 pixels, region 64x32.

Source files
------------

// File: rtl/score_text_overlay_if.sv
// -----------------------------------------------------------------------------
// score_text_overlay_if
//   Score-load handshake between the game logic (master) and the score
//   renderer (slave).
//   score_in   : new score value, sampled together with score_load
//   score_load : one-cycle strobe, taken only while busy is low
//   busy       : conversion in progress, driven by the renderer
// -----------------------------------------------------------------------------
interface score_text_overlay_if #(
  parameter int SCORE_W = 14
);
  logic [SCORE_W-1:0] score_in;
  logic               score_load;
  logic               busy;

  modport master (output score_in, output score_load, input busy);
  modport slave  (input score_in, input score_load, output busy);
endinterface

// File: rtl/score_text_overlay.sv
// -----------------------------------------------------------------------------
// score_text_overlay
//   Draws an unsigned binary score as DIGITS decimal characters at (X0,Y0) in
//   the VGA pixel stream. The score is converted to BCD one bit per clock
//   (double-dabble), saturated to all nines when it does not fit, held as a
//   pending value and copied to the displayed value only while y >= V_ACTIVE,
//   so a frame never shows a mix of old and new digits. Leading zeros can be
//   blanked and the glyphs can be magnified by 2**SCALE_LOG2.
//
// Ports
//   clk        pixel clock
//   reset      synchronous, active-high
//   video_on   active-video flag, aligned with x/y
//   x, y       current pixel column / row
//   score_bus  slave side of the score-load handshake (score_in, score_load,
//              busy)
//   text_on    glyph pixel lit, registered, aligned with rgb
//   rgb        pixel colour, registered; two clocks after x/y/video_on
// -----------------------------------------------------------------------------
module score_text_overlay #(
  parameter int          DIGITS     = 4,
  parameter int          SCORE_W    = 14,
  parameter int          X0         = 24,
  parameter int          Y0         = 20,
  parameter int          SCALE_LOG2 = 0,
  parameter int          LZ_BLANK   = 1,
  parameter int          V_ACTIVE   = 480,
  parameter logic [11:0] FG         = 12'hFFF,
  parameter logic [11:0] BG         = 12'h000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       video_on,
  input  logic [9:0]                 x,
  input  logic [9:0]                 y,
  score_text_overlay_if.slave        score_bus,
  output logic                       text_on,
  output logic [11:0]                rgb
);

  localparam int CW    = 8 << SCALE_LOG2;
  localparam int CH    = 16 << SCALE_LOG2;
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(SCORE_W + 1);

  // Region bounds kept in 11 bits so a region running past column 1023 does
  // not wrap; the part beyond the screen simply never matches.
  localparam logic [10:0] X0_L    = 11'(X0);
  localparam logic [10:0] X_END_L = 11'(X0 + DIGITS * CW);
  localparam logic [10:0] Y0_L    = 11'(Y0);
  localparam logic [10:0] Y_END_L = 11'(Y0 + CH);
  localparam logic [10:0] V_ACT_L = 11'(V_ACTIVE);

  localparam logic [31:0]      MAX_VAL   = 32'(10 ** DIGITS - 1);
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Conversion and commit state
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [SCORE_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic               pend_q, pend_d;
  logic [BCD_W-1:0]   pend_bcd_q, pend_bcd_d;
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic [BCD_W-1:0]   bcd_adj;
  logic [10:0]        y_e;

  assign y_e = {1'b0, y};

  // Double-dabble correction: every digit >= 5 gets +3 before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                  bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
    end
  endgenerate

  assign score_bus.busy = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_bcd_q <= '0;
      disp_q     <= '0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      pend_q     <= pend_d;
      pend_bcd_q <= pend_bcd_d;
      disp_q     <= disp_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    pend_d     = pend_q;
    pend_bcd_d = pend_bcd_q;
    disp_d     = disp_q;

    case (state_q)
      S_IDLE: begin
        if (score_bus.score_load) begin
          bin_d   = score_bus.score_in;
          bcd_d   = '0;
          cnt_d   = '0;
          sat_d   = (32'(score_bus.score_in) > MAX_VAL);
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        // Bits shifted out of the top digit are lost; that only happens for
        // values that are saturated anyway.
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SCORE_W - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Commit uses the pending value as it stood at the start of the cycle; a
    // conversion finishing in the same cycle lands in pending afterwards and
    // waits for the next eligible cycle.
    if (pend_q && (y_e >= V_ACT_L)) begin
      disp_d = pend_bcd_q;
      pend_d = 1'b0;
    end
    if (state_q == S_DONE) begin
      pend_bcd_d = sat_q ? ALL_NINES : bcd_q;
      pend_d     = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Character codes for the displayed digits (index 0 = leftmost)
  // ---------------------------------------------------------------------------
  logic [6:0] char_arr [DIGITS];

  always_comb begin
    logic       lz_run;
    logic [3:0] dig;
    lz_run = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      dig    = disp_q[4*(DIGITS-1-i) +: 4];
      lz_run = lz_run && (dig == 4'd0);
      // The rightmost digit is always drawn so a zero score shows "0".
      if ((LZ_BLANK != 0) && (i != DIGITS - 1) && lz_run) begin
        char_arr[i] = 7'h20;
      end else begin
        char_arr[i] = {3'b011, dig};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel pipeline
  //   cycle 0 : region decode, ROM address presented (ROM registers it)
  //   cycle 1 : ROM data valid, col/in_region/video_on delayed alongside
  //   cycle 2 : rgb/text_on registered
  // ---------------------------------------------------------------------------
  logic [10:0] x_e, dx, dy;
  logic        in_region;
  logic [2:0]  idx;
  logic [2:0]  col;
  logic [3:0]  row;
  logic [6:0]  char_sel;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;

  always_comb begin
    x_e       = {1'b0, x};
    in_region = (x_e >= X0_L) && (x_e < X_END_L) &&
                (y_e >= Y0_L) && (y_e < Y_END_L);
    dx        = x_e - X0_L;
    dy        = y_e - Y0_L;
    idx       = 3'(dx >> (3 + SCALE_LOG2));
    col       = 3'(dx >> SCALE_LOG2);
    row       = 4'(dy >> SCALE_LOG2);
    char_sel  = 7'h20;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == 3'(i)) begin
        char_sel = char_arr[i];
      end
    end
    rom_addr = {char_sel, row};
  end

  ascii_rom_score u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  logic [2:0]  col_q;
  logic        in_region_q;
  logic        video_on_q;
  logic [11:0] rgb_q;
  logic        text_on_q;
  logic        lit;

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q       <= '0;
      in_region_q <= 1'b0;
      video_on_q  <= 1'b0;
    end else begin
      col_q       <= col;
      in_region_q <= in_region;
      video_on_q  <= video_on;
    end
  end

  // Glyph MSB is the leftmost pixel, hence the inverted column.
  assign lit = in_region_q && rom_data[~col_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q     <= 12'h000;
      text_on_q <= 1'b0;
    end else if (!video_on_q) begin
      rgb_q     <= 12'h000;
      text_on_q <= 1'b0;
    end else if (lit) begin
      rgb_q     <= FG;
      text_on_q <= 1'b1;
    end else begin
      rgb_q     <= BG;
      text_on_q <= 1'b0;
    end
  end

  assign rgb     = rgb_q;
  assign text_on = text_on_q;

endmodule

// -----------------------------------------------------------------------------
// ascii_rom_score
//   8x16 glyph ROM with a registered read; data is valid one clock after addr.
//   addr = {char[6:0], row[3:0]}; data bit 7 is the leftmost pixel.
//   Only the digits '0'..'9' carry pixels; every other code (including the
//   space used for blanked digits) reads as empty.
// -----------------------------------------------------------------------------
module ascii_rom_score (
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  data
);

  localparam logic [127:0] GLYPH [10] = '{
    128'h00007CC6C6CEDEF6E6C6C67C00000000,  // 0
    128'h00001838781818181818187E00000000,  // 1
    128'h00007CC6060C183060C0C6FE00000000,  // 2
    128'h00007CC606063C060606C67C00000000,  // 3
    128'h00000C1C3C6CCCFE0C0C0C1E00000000,  // 4
    128'h0000FEC0C0C0FC060606C67C00000000,  // 5
    128'h00003860C0C0FCC6C6C6C67C00000000,  // 6
    128'h0000FEC606060C183030303000000000,  // 7
    128'h00007CC6C6C67CC6C6C6C67C00000000,  // 8
    128'h00007CC6C6C67E0606060C7800000000   // 9
  };

  logic [6:0] code;
  logic [3:0] row;
  logic [7:0] data_q;

  assign code = addr[10:4];
  assign row  = addr[3:0];

  // Row 0 sits in the top byte of each glyph word: byte offset 8*(15-row).
  always_ff @(posedge clk) begin
    if ((code >= 7'h30) && (code <= 7'h39)) begin
      data_q <= GLYPH[4'(code - 7'h30)][{~row, 3'b000} +: 8];
    end else begin
      data_q <= 8'h00;
    end
  end

  assign data = data_q;

endmodule

// File: tb/tb_score_text_overlay.sv
module tb_score_text_overlay;

  logic        clk = 1'b0;
  logic        reset;
  logic        video_on;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [11:0] rgb0, rgb1;
  logic        text_on0, text_on1;

  always #5 clk = ~clk;

  score_text_overlay_if #(.SCORE_W(14)) bus0 ();
  score_text_overlay_if #(.SCORE_W(14)) bus1 ();

  // Unscaled instance
  score_text_overlay #(
    .DIGITS(4), .SCORE_W(14), .X0(24), .Y0(20), .SCALE_LOG2(0),
    .LZ_BLANK(1), .V_ACTIVE(480), .FG(12'hFFF), .BG(12'h000)
  ) dut0 (
    .clk(clk), .reset(reset), .video_on(video_on), .x(x), .y(y),
    .score_bus(bus0), .text_on(text_on0), .rgb(rgb0)
  );

  // 2x magnified instance, fed the same stimulus
  score_text_overlay #(
    .DIGITS(4), .SCORE_W(14), .X0(24), .Y0(20), .SCALE_LOG2(1),
    .LZ_BLANK(1), .V_ACTIVE(480), .FG(12'hFFF), .BG(12'h000)
  ) dut1 (
    .clk(clk), .reset(reset), .video_on(video_on), .x(x), .y(y),
    .score_bus(bus1), .text_on(text_on1), .rgb(rgb1)
  );

  localparam logic [127:0] FONT [10] = '{
    128'h00007CC6C6CEDEF6E6C6C67C00000000,
    128'h00001838781818181818187E00000000,
    128'h00007CC6060C183060C0C6FE00000000,
    128'h00007CC606063C060606C67C00000000,
    128'h00000C1C3C6CCCFE0C0C0C1E00000000,
    128'h0000FEC0C0C0FC060606C67C00000000,
    128'h00003860C0C0FCC6C6C6C67C00000000,
    128'h0000FEC606060C183030303000000000,
    128'h00007CC6C6C67CC6C6C6C67C00000000,
    128'h00007CC6C6C67E0606060C7800000000
  };

  int vectors     = 0;
  int miscompares = 0;
  int shown       = 0;   // value the bench expects on screen right now

  logic [12:0] q0 [$];
  logic [12:0] q1 [$];

  // Expected {text_on, rgb} for one pixel, from the on-screen value.
  function automatic logic [12:0] model_pix(int xx, int yy, logic von, int val, int s);
    int cw, ch, dx, dy, idx, col, row, dig, pw;
    logic [127:0] g;
    logic [7:0]   bits;
    if (!von) return 13'h0;
    cw = 8 << s;
    ch = 16 << s;
    if (xx < 24 || xx >= 24 + 4 * cw || yy < 20 || yy >= 20 + ch) return 13'h0;
    dx  = xx - 24;
    dy  = yy - 20;
    idx = dx / cw;
    col = (dx >> s) % 8;
    row = (dy >> s) % 16;
    pw  = 1;
    for (int k = 0; k < 3 - idx; k++) pw = pw * 10;
    dig = (val / pw) % 10;
    if (idx < 3 && val < pw) return 13'h0;   // blanked leading zero
    g    = FONT[dig];
    bits = g[127 - 8 * row -: 8];
    if (bits[7 - col]) return {1'b1, 12'hFFF};
    return 13'h0;
  endfunction

  task automatic chk(string tag, logic [12:0] obs, logic [12:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h x=%0d y=%0d t=%0t", tag, obs, exp, x, y, $time);
    end
  endtask

  task automatic chk_busy(logic b);
    chk("busy_s0", {12'd0, bus0.busy}, {12'd0, b});
    chk("busy_s1", {12'd0, bus1.busy}, {12'd0, b});
  endtask

  // One pixel clock: push expectation for the current pixel, clock, then
  // compare the output belonging to the pixel driven one step earlier.
  task automatic step();
    q0.push_back(model_pix(int'(x), int'(y), video_on, shown, 0));
    q1.push_back(model_pix(int'(x), int'(y), video_on, shown, 1));
    @(posedge clk);
    #1;
    if (q0.size() >= 2) chk("pix_s0", {text_on0, rgb0}, q0.pop_front());
    if (q1.size() >= 2) chk("pix_s1", {text_on1, rgb1}, q1.pop_front());
  endtask

  task automatic set_score(int v);
    bus0.score_in = 14'(v);
    bus1.score_in = 14'(v);
  endtask

  task automatic set_load(logic l);
    bus0.score_load = l;
    bus1.score_load = l;
  endtask

  task automatic park(int yy);
    x = 10'd0;
    y = 10'(yy);
    video_on = 1'b1;
  endtask

  task automatic load_and_wait(int v);
    park(100);
    set_score(v);
    set_load(1'b1);
    step();
    set_load(1'b0);
    for (int i = 0; i < 15; i++) begin
      chk_busy(1'b1);
      step();
    end
    chk_busy(1'b0);
  endtask

  task automatic vblank();
    x = 10'd0;
    y = 10'd480;
    video_on = 1'b0;
    step();
    park(100);
  endtask

  task automatic scan();
    for (int yy = 18; yy <= 54; yy++) begin
      for (int xx = 22; xx <= 90; xx++) begin
        x = 10'(xx);
        y = 10'(yy);
        video_on = 1'b1;
        step();
      end
    end
    park(100);
  endtask

  initial begin
    reset    = 1'b1;
    video_on = 1'b0;
    x        = 10'd0;
    y        = 10'd0;
    set_score(0);
    set_load(1'b0);

    // Reset held for three clocks
    for (int i = 0; i < 3; i++) step();
    chk_busy(1'b0);
    reset = 1'b0;

    // 1234 loaded on the first cycle after reset, mid-frame
    load_and_wait(1234);
    scan();                      // still the reset display "   0"
    vblank();
    shown = 1234;
    scan();

    // Saturation
    load_and_wait(12000);
    vblank();
    shown = 9999;
    scan();

    // Single-pixel probes with video_on toggling
    for (int i = 0; i < 8; i++) begin
      x = 10'd25;
      y = 10'd22;
      video_on = (i % 3 != 1);
      step();
    end
    for (int i = 0; i < 6; i++) begin
      x = 10'd24;
      y = 10'd20;
      video_on = i[0];
      step();
    end
    park(100);

    // Load while busy is ignored
    set_score(7);
    set_load(1'b1);
    step();
    chk_busy(1'b1);
    set_score(3333);
    step();
    set_load(1'b0);
    for (int i = 0; i < 14; i++) begin
      chk_busy(1'b1);
      step();
    end
    chk_busy(1'b0);
    vblank();
    shown = 7;
    scan();

    // Two conversions before vblank: latest wins
    load_and_wait(500);
    load_and_wait(42);
    scan();                      // still "   7"
    vblank();
    shown = 42;
    scan();

    // Zero
    load_and_wait(0);
    vblank();
    shown = 0;
    scan();

    // Reset in the middle of a conversion
    load_and_wait(3);
    vblank();
    shown = 3;
    video_on = 1'b0;
    set_score(5555);
    set_load(1'b1);
    step();
    set_load(1'b0);
    for (int i = 0; i < 3; i++) step();
    chk_busy(1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    shown = 0;
    chk_busy(1'b0);
    load_and_wait(88);           // accepted right after reset
    scan();                      // display zeroed by reset
    vblank();
    shown = 88;
    scan();

    // drain the last in-flight pixel
    video_on = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
